freq_inversion_nch: RTL and testbench
=====================================

FREQ_INVERSION_NCH -- requirements
Module: freq_inversion_nch

Interface
REQ-001 Parameter CHANNELS, default 2, number of granule channels processed in lockstep (1..4).
REQ-002 Parameter DATA_W, default 18, two's-complement sample width.
REQ-003 Parameter ADDR_W, default 10, granule RAM address width.
REQ-004 Parameter LINES, default 576, samples per granule; SHALL be a multiple of SB_LEN.
REQ-005 Parameter SB_LEN, default 18, samples per subband.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 stage_ready  in  1  start request, sampled only in IDLE.
REQ-009 ch_enable  in  CHANNELS  per-channel process mask, captured at start.
REQ-010 start_sb  in  6  first subband eligible for inversion (mixed-block support), captured at start.
REQ-011 read_addr  out  ADDR_W  shared granule RAM read address (1-cycle synchronous read RAM).
REQ-012 read_data  in  CHANNELS*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
REQ-013 write_enable  out  CHANNELS  per-channel write strobe.
REQ-014 write_addr  out  ADDR_W  shared write address.
REQ-015 write_data  out  CHANNELS*DATA_W  packed as read_data.
REQ-016 busy  out  1  high from start until stage_done.
REQ-017 stage_done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on stage_ready; RUN->DRAIN after read_addr=LINES-1; DRAIN->DONE after last write; DONE->IDLE unconditionally after one cycle.
REQ-019 Start edge (cycle 0): ch_enable and start_sb registered; read_addr=0 in cycle 1, incremented by 1 each cycle through LINES-1, then held at 0.
REQ-020 Sample read at address k in cycle t SHALL be written to address k in cycle t+2 (write latency 2); writes strictly sequential, no gaps.
REQ-021 Subband index sb and in-subband index i SHALL be tracked with counters (no divider); i wraps SB_LEN-1 -> 0 incrementing sb.
REQ-022 Sample negated iff sb odd AND i odd AND sb >= start_sb; otherwise copied unchanged.
REQ-023 Negation = two's complement in DATA_W bits; most-negative value handled per REQ-033.
REQ-024 write_enable[c] = 1 only during the LINES write cycles and only if captured ch_enable[c]=1; disabled channels get write_enable[c]=0 and write_data passthrough.
REQ-025 stage_done high exactly one cycle (DONE state), cycle LINES+3 after the start edge; busy falls in the same cycle.
REQ-026 stage_ready while busy SHALL be ignored; stage_ready held high in DONE starts a new pass only once IDLE is reached.
REQ-027 start_sb >= LINES/SB_LEN SHALL yield a pure copy; start_sb=0 gives full-granule inversion.
REQ-028 ch_enable all-zero SHALL still run full timing and pulse stage_done with no writes.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; read_addr, write_addr, write_data, write_enable, busy, stage_done, counters all 0.
REQ-030 Reset asserted mid-pass SHALL abort with no further writes and no stage_done; next pass requires a fresh stage_ready.
REQ-031 After rst_n release, first stage_ready is honoured on the first rising edge.

Configuration
REQ-032 Macro FREQ_INV_SATURATE_EN selects negation overflow handling.
REQ-033 Defined: negating -2^(DATA_W-1) yields 2^(DATA_W-1)-1; undefined: result wraps to -2^(DATA_W-1) (plain two's complement).

Verification
REQ-034 CHANNELS=2, all enabled, start_sb=0, RAM[k]=k+1 -> addr 19 (sb1,i1) written -20, addr 18 written 19, addr 1 written 2; stage_done at cycle 579.
REQ-035 start_sb=2 -> addr 19 written 20 unchanged; addr 55 (sb3,i1) written -56.
REQ-036 ch_enable=2'b10 -> write_enable[0] never high; write_enable[1] high exactly 576 cycles.
REQ-037 Sample 0x20000 at addr 19: with FREQ_INV_SATURATE_EN -> 0x1FFFF; without -> 0x20000.
REQ-038 rst_n low at cycle 300 -> outputs 0 same cycle, no stage_done; new stage_ready -> full correct pass.
REQ-039 stage_ready pulsed at cycle 100 of a pass -> ignored; single stage_done at cycle 579.

Source files
------------

// File: rtl/freq_inversion_nch_if.sv
// Granule RAM port bundle for freq_inversion_nch: shared read/write addresses,
// packed per-channel read data, write strobes and write data.
interface freq_inversion_nch_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 10
);
    logic [ADDR_W-1:0]          read_addr;
    logic [CHANNELS*DATA_W-1:0] read_data;
    logic [CHANNELS-1:0]        write_enable;
    logic [ADDR_W-1:0]          write_addr;
    logic [CHANNELS*DATA_W-1:0] write_data;

    modport master (
        output read_addr,
        input  read_data,
        output write_enable,
        output write_addr,
        output write_data
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  write_enable,
        input  write_addr,
        input  write_data
    );
endinterface

// File: rtl/freq_inversion_nch.sv
// Frequency inversion over a granule: negates odd samples of odd subbands from start_sb on,
// all channels in lockstep. Define FREQ_INV_SATURATE_EN to saturate negation of the most-negative value.
module freq_inversion_nch #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 10,
    parameter int LINES    = 576,
    parameter int SB_LEN   = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stage_ready,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic [5:0]          start_sb,
    freq_inversion_nch_if.master ram,
    output logic                busy,
    output logic                stage_done
);

    localparam int SB_COUNT = LINES / SB_LEN;
    localparam int SB_W     = ($clog2(SB_COUNT + 1) > 6) ? $clog2(SB_COUNT + 1) : 6;
    localparam int I_W      = (SB_LEN > 1) ? $clog2(SB_LEN) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINES - 1);
    localparam logic [I_W-1:0]    LAST_I    = I_W'(SB_LEN - 1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [CHANNELS-1:0]        ch_en_q;
    logic [SB_W-1:0]            start_sb_q;
    logic [ADDR_W-1:0]          read_addr_q;
    logic                       rd_valid;
    logic                       rdata_valid;
    logic [ADDR_W-1:0]          rdata_addr;
    logic [SB_W-1:0]            sb_cnt;
    logic [I_W-1:0]             i_cnt;
    logic                       wr_valid;
    logic [ADDR_W-1:0]          write_addr_q;
    logic [CHANNELS-1:0]        write_enable_q;
    logic [CHANNELS*DATA_W-1:0] write_data_q;
    logic [CHANNELS*DATA_W-1:0] proc_data;
    logic                       start;
    logic                       read_last;
    logic                       wr_last;
    logic                       negate_now;

    assign start     = (state == IDLE) && stage_ready;
    assign read_last = (state == RUN) && rd_valid && (read_addr_q == LAST_ADDR);
    assign wr_last   = wr_valid && (write_addr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stage_ready) state_nxt = RUN;
            RUN:     if (read_last)   state_nxt = DRAIN;
            DRAIN:   if (wr_last)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first RUN cycle only arms the read pointer, so address 0 is issued one cycle after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_en_q     <= '0;
            start_sb_q  <= '0;
            read_addr_q <= '0;
            rd_valid    <= 1'b0;
        end else if (start) begin
            ch_en_q     <= ch_enable;
            start_sb_q  <= SB_W'(start_sb);
            read_addr_q <= '0;
            rd_valid    <= 1'b0;
        end else if (state == RUN) begin
            if (!rd_valid) begin
                rd_valid <= 1'b1;
            end else if (read_addr_q == LAST_ADDR) begin
                rd_valid    <= 1'b0;
                read_addr_q <= '0;
            end else begin
                read_addr_q <= read_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_valid <= 1'b0;
            rdata_addr  <= '0;
            sb_cnt      <= '0;
            i_cnt       <= '0;
        end else begin
            rdata_valid <= rd_valid;
            rdata_addr  <= read_addr_q;
            if (start) begin
                sb_cnt <= '0;
                i_cnt  <= '0;
            end else if (rdata_valid) begin
                if (i_cnt == LAST_I) begin
                    i_cnt  <= '0;
                    sb_cnt <= sb_cnt + SB_W'(1);
                end else begin
                    i_cnt <= i_cnt + I_W'(1);
                end
            end
        end
    end

    assign negate_now = sb_cnt[0] && i_cnt[0] && (sb_cnt >= start_sb_q);

    // Disabled channels pass their sample through untouched even though they are not written.
    always_comb begin
        proc_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic [DATA_W-1:0] sample;
            logic [DATA_W-1:0] negated;
            sample  = ram.read_data[c*DATA_W +: DATA_W];
            negated = (~sample) + DATA_W'(1);
`ifdef FREQ_INV_SATURATE_EN
            if (sample == MOST_NEG) negated = MOST_POS;
`endif
            if (negate_now && ch_en_q[c]) proc_data[c*DATA_W +: DATA_W] = negated;
            else                          proc_data[c*DATA_W +: DATA_W] = sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid       <= 1'b0;
            write_addr_q   <= '0;
            write_enable_q <= '0;
            write_data_q   <= '0;
        end else begin
            wr_valid <= rdata_valid;
            if (rdata_valid) begin
                write_addr_q   <= rdata_addr;
                write_data_q   <= proc_data;
                write_enable_q <= ch_en_q;
            end else begin
                write_enable_q <= '0;
            end
        end
    end

    assign ram.read_addr    = read_addr_q;
    assign ram.write_addr   = write_addr_q;
    assign ram.write_enable = write_enable_q;
    assign ram.write_data   = write_data_q;
    assign busy             = (state == RUN) || (state == DRAIN);
    assign stage_done       = (state == DONE);

`ifndef FREQ_INV_SATURATE_EN
    logic unused_sat_consts;
    assign unused_sat_consts = ^{MOST_NEG, MOST_POS};
`endif

endmodule

// File: tb/tb_freq_inversion_nch.sv
// Self-checking bench for freq_inversion_nch: behavioural RAM, per-pass observation capture,
// and a divide/modulo reference model of the inversion rule.
module tb_freq_inversion_nch;

    localparam int CH    = 2;
    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int LINES = 576;
    localparam int SBL   = 18;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stage_ready;
    logic [CH-1:0] ch_enable;
    logic [5:0]    start_sb;
    logic          busy;
    logic          stage_done;

    int n_vectors     = 0;
    int n_miscompares = 0;

    freq_inversion_nch_if #(.CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW)) ram_if ();

    freq_inversion_nch #(
        .CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW), .LINES(LINES), .SB_LEN(SBL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_ready (stage_ready),
        .ch_enable   (ch_enable),
        .start_sb    (start_sb),
        .ram         (ram_if),
        .busy        (busy),
        .stage_done  (stage_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    mem [0:CH-1][0:DEPTH-1];
    logic [CH*DW-1:0] rd_reg;

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) rd_reg[c*DW +: DW] <= mem[c][ram_if.read_addr];
    end
    assign ram_if.read_data = rd_reg;

    logic [DW-1:0]    obs_wr_data  [0:CH-1][0:DEPTH-1];
    logic [DW-1:0]    obs_pt       [0:CH-1][0:DEPTH-1];
    int               obs_wr_cycle [0:CH-1][0:DEPTH-1];
    int               obs_we_cnt   [0:CH-1];
    logic [AW-1:0]    obs_raddr    [0:2047];
    logic             obs_busy     [0:2047];
    int               obs_done_q[$];
    int               obs_wr_after_rst;
    int               obs_busy_after_rel;
    logic [AW-1:0]    obs_rst_raddr, obs_rst_waddr;
    logic [CH-1:0]    obs_rst_we;
    logic [CH*DW-1:0] obs_rst_wdata;
    logic             obs_rst_busy, obs_rst_done;

    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] x, input int k, input int ssb);
        int sb = k / SBL;
        int i  = k % SBL;
        int v;
        if ((sb % 2 == 1) && (i % 2 == 1) && (sb >= ssb)) begin
`ifdef FREQ_INV_SATURATE_EN
            if ($signed(x) == -(1 << (DW - 1))) return DW'((1 << (DW - 1)) - 1);
`endif
            v = -int'($signed(x));
            return DW'(v);
        end
        return x;
    endfunction

    task automatic fill_mem(input bit ramp);
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < DEPTH; k++)
                mem[c][k] = (ramp && c == 0) ? DW'(k + 1) : DW'($urandom);
    endtask

    task automatic do_pass(input logic [CH-1:0] en, input logic [5:0] ssb, input int n_cycles,
                           input int extra_ready, input int reset_cycle, input bit hold_ready);
        for (int c = 0; c < CH; c++) begin
            obs_we_cnt[c] = 0;
            for (int k = 0; k < DEPTH; k++) begin
                obs_wr_data[c][k]  = '0;
                obs_pt[c][k]       = '0;
                obs_wr_cycle[c][k] = -1;
            end
        end
        obs_done_q.delete();
        obs_wr_after_rst   = 0;
        obs_busy_after_rel = 0;
        @(negedge clk);
        ch_enable   = en;
        start_sb    = ssb;
        stage_ready = 1'b1;
        @(posedge clk);
        for (int n = 0; n < n_cycles; n++) begin
            @(negedge clk);
            if (n < 2048) begin
                obs_raddr[n] = ram_if.read_addr;
                obs_busy[n]  = busy;
            end
            if (stage_done) obs_done_q.push_back(n);
            for (int c = 0; c < CH; c++) begin
                if (ram_if.write_enable[c]) begin
                    obs_we_cnt[c]++;
                    obs_wr_data[c][ram_if.write_addr]  = ram_if.write_data[c*DW +: DW];
                    obs_wr_cycle[c][ram_if.write_addr] = n;
                end
                if (|ram_if.write_enable) obs_pt[c][ram_if.write_addr] = ram_if.write_data[c*DW +: DW];
            end
            if (reset_cycle >= 0 && n > reset_cycle && |ram_if.write_enable) obs_wr_after_rst++;
            if (reset_cycle >= 0 && n > reset_cycle + 3 && busy) obs_busy_after_rel++;
            stage_ready = hold_ready || (n == extra_ready);
            if (n == 0) begin
                ch_enable = ~en;
                start_sb  = 6'($urandom);
            end
            if (n == reset_cycle) begin
                rst_n = 1'b0;
                #1;
                obs_rst_raddr = ram_if.read_addr;
                obs_rst_waddr = ram_if.write_addr;
                obs_rst_we    = ram_if.write_enable;
                obs_rst_wdata = ram_if.write_data;
                obs_rst_busy  = busy;
                obs_rst_done  = stage_done;
            end
            if (reset_cycle >= 0 && n == reset_cycle + 3) rst_n = 1'b1;
        end
        stage_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stage_ready = 1'b0; ch_enable = '0; start_sb = '0;
        fill_mem(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vectors++; if (busy !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
        n_vectors++; if (stage_done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset_done: got %0b, expected 0", stage_done); end
        n_vectors++; if (ram_if.read_addr !== '0) begin n_miscompares++; $display("[TB] FAIL reset_raddr: got %0d, expected 0", ram_if.read_addr); end
        n_vectors++; if (ram_if.write_addr !== '0) begin n_miscompares++; $display("[TB] FAIL reset_waddr: got %0d, expected 0", ram_if.write_addr); end
        n_vectors++; if (ram_if.write_enable !== '0) begin n_miscompares++; $display("[TB] FAIL reset_we: got %b, expected 0", ram_if.write_enable); end
        n_vectors++; if (ram_if.write_data !== '0) begin n_miscompares++; $display("[TB] FAIL reset_wdata: got %h, expected 0", ram_if.write_data); end
        rst_n = 1'b1; stage_ready = 1'b1; ch_enable = '1;
        @(negedge clk);
        stage_ready = 1'b0;
        n_vectors++; if (busy !== 1'b1) begin n_miscompares++; $display("[TB] FAIL first_edge_start: got %0b, expected 1", busy); end
        repeat (LINES + 6) @(negedge clk);
        n_vectors++; if (busy !== 1'b0) begin n_miscompares++; $display("[TB] FAIL idle_after_pass: got %0b, expected 0", busy); end
    endtask

    task automatic test_full_inversion;
        fill_mem(1'b1);
        do_pass(2'b11, 6'd0, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if (obs_wr_data[0][19] !== 18'h3FFEC) begin n_miscompares++; $display("[TB] FAIL addr19_neg: got %h, expected 3ffec", obs_wr_data[0][19]); end
        n_vectors++; if (obs_wr_data[0][18] !== 18'd19) begin n_miscompares++; $display("[TB] FAIL addr18_copy: got %0d, expected 19", obs_wr_data[0][18]); end
        n_vectors++; if (obs_wr_data[0][1] !== 18'd2) begin n_miscompares++; $display("[TB] FAIL addr1_copy: got %0d, expected 2", obs_wr_data[0][1]); end
        n_vectors++; if (obs_done_q.size() !== 1) begin n_miscompares++; $display("[TB] FAIL done_count: got %0d, expected 1", obs_done_q.size()); end
        n_vectors++; if ((obs_done_q.size() > 0 ? obs_done_q[0] : -1) !== LINES + 3) begin n_miscompares++; $display("[TB] FAIL done_cycle: got %0d, expected %0d", (obs_done_q.size() > 0 ? obs_done_q[0] : -1), LINES + 3); end
        n_vectors++; if (obs_raddr[1] !== 10'd0 || obs_raddr[2] !== 10'd1) begin n_miscompares++; $display("[TB] FAIL raddr_start: got %0d/%0d, expected 0/1", obs_raddr[1], obs_raddr[2]); end
        n_vectors++; if (obs_raddr[LINES] !== 10'(LINES - 1) || obs_raddr[LINES + 1] !== 10'd0) begin n_miscompares++; $display("[TB] FAIL raddr_end: got %0d/%0d, expected %0d/0", obs_raddr[LINES], obs_raddr[LINES + 1], LINES - 1); end
        n_vectors++; if (obs_busy[0] !== 1'b1 || obs_busy[LINES + 2] !== 1'b1 || obs_busy[LINES + 3] !== 1'b0) begin n_miscompares++; $display("[TB] FAIL busy_window: got %0b%0b%0b, expected 110", obs_busy[0], obs_busy[LINES + 2], obs_busy[LINES + 3]); end
        for (int c = 0; c < CH; c++) begin
            n_vectors++; if (obs_we_cnt[c] !== LINES) begin n_miscompares++; $display("[TB] FAIL we_count ch%0d: got %0d, expected %0d", c, obs_we_cnt[c], LINES); end
            for (int k = 0; k < LINES; k++) begin
                n_vectors++; if (obs_wr_data[c][k] !== model_out(mem[c][k], k, 0)) begin n_miscompares++; $display("[TB] FAIL data ch%0d k%0d: got %h, expected %h", c, k, obs_wr_data[c][k], model_out(mem[c][k], k, 0)); end
                n_vectors++; if (obs_wr_cycle[c][k] !== k + 3) begin n_miscompares++; $display("[TB] FAIL write_cycle ch%0d k%0d: got %0d, expected %0d", c, k, obs_wr_cycle[c][k], k + 3); end
            end
        end
    endtask

    task automatic test_start_sb;
        int ssb;
        fill_mem(1'b1);
        do_pass(2'b11, 6'd2, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if (obs_wr_data[0][19] !== 18'd20) begin n_miscompares++; $display("[TB] FAIL sb1_kept: got %0d, expected 20", obs_wr_data[0][19]); end
        n_vectors++; if (obs_wr_data[0][55] !== 18'h3FFC8) begin n_miscompares++; $display("[TB] FAIL sb3_neg: got %h, expected 3ffc8", obs_wr_data[0][55]); end
        for (int p = 0; p < 3; p++) begin
            fill_mem(1'b0);
            ssb = int'($urandom_range(0, 33));
            do_pass(2'b11, 6'(ssb), LINES + 6, -1, -1, 1'b0);
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < LINES; k++) begin
                    n_vectors++; if (obs_wr_data[c][k] !== model_out(mem[c][k], k, ssb)) begin n_miscompares++; $display("[TB] FAIL rand_sb%0d ch%0d k%0d: got %h, expected %h", ssb, c, k, obs_wr_data[c][k], model_out(mem[c][k], k, ssb)); end
                end
        end
    endtask

    task automatic test_channel_mask;
        fill_mem(1'b0);
        do_pass(2'b10, 6'd0, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if (obs_we_cnt[0] !== 0) begin n_miscompares++; $display("[TB] FAIL we0_count: got %0d, expected 0", obs_we_cnt[0]); end
        n_vectors++; if (obs_we_cnt[1] !== LINES) begin n_miscompares++; $display("[TB] FAIL we1_count: got %0d, expected %0d", obs_we_cnt[1], LINES); end
        n_vectors++; if (obs_pt[0][19] !== mem[0][19]) begin n_miscompares++; $display("[TB] FAIL ch0_passthrough: got %h, expected %h", obs_pt[0][19], mem[0][19]); end
        for (int k = 0; k < LINES; k++) begin
            n_vectors++; if (obs_wr_data[1][k] !== model_out(mem[1][k], k, 0)) begin n_miscompares++; $display("[TB] FAIL mask_data k%0d: got %h, expected %h", k, obs_wr_data[1][k], model_out(mem[1][k], k, 0)); end
        end
    endtask

    task automatic test_saturation;
        logic [DW-1:0] expv;
`ifdef FREQ_INV_SATURATE_EN
        expv = 18'h1FFFF;
`else
        expv = 18'h20000;
`endif
        fill_mem(1'b1);
        mem[0][19] = 18'h20000;
        mem[1][37] = 18'h20000;
        do_pass(2'b11, 6'd0, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if (obs_wr_data[0][19] !== expv) begin n_miscompares++; $display("[TB] FAIL most_negative: got %h, expected %h", obs_wr_data[0][19], expv); end
        n_vectors++; if (obs_wr_data[1][37] !== 18'h20000) begin n_miscompares++; $display("[TB] FAIL most_neg_even_sb: got %h, expected 20000", obs_wr_data[1][37]); end
    endtask

    task automatic test_mid_reset;
        fill_mem(1'b0);
        do_pass(2'b11, 6'd0, LINES + 6, -1, 300, 1'b0);
        n_vectors++; if ({obs_rst_raddr, obs_rst_waddr} !== '0) begin n_miscompares++; $display("[TB] FAIL rst_addrs: got %0d/%0d, expected 0/0", obs_rst_raddr, obs_rst_waddr); end
        n_vectors++; if (obs_rst_we !== '0 || obs_rst_wdata !== '0) begin n_miscompares++; $display("[TB] FAIL rst_write: got we=%b data=%h, expected 0", obs_rst_we, obs_rst_wdata); end
        n_vectors++; if (obs_rst_busy !== 1'b0 || obs_rst_done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL rst_status: got busy=%0b done=%0b, expected 0", obs_rst_busy, obs_rst_done); end
        n_vectors++; if (obs_done_q.size() !== 0) begin n_miscompares++; $display("[TB] FAIL rst_no_done: got %0d, expected 0", obs_done_q.size()); end
        n_vectors++; if (obs_wr_after_rst !== 0) begin n_miscompares++; $display("[TB] FAIL rst_no_writes: got %0d, expected 0", obs_wr_after_rst); end
        n_vectors++; if (obs_busy_after_rel !== 0) begin n_miscompares++; $display("[TB] FAIL rst_needs_ready: got %0d, expected 0", obs_busy_after_rel); end
        fill_mem(1'b0);
        do_pass(2'b11, 6'd5, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if ((obs_done_q.size() > 0 ? obs_done_q[0] : -1) !== LINES + 3) begin n_miscompares++; $display("[TB] FAIL post_rst_done: got %0d, expected %0d", (obs_done_q.size() > 0 ? obs_done_q[0] : -1), LINES + 3); end
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < LINES; k++) begin
                n_vectors++; if (obs_wr_data[c][k] !== model_out(mem[c][k], k, 5)) begin n_miscompares++; $display("[TB] FAIL post_rst_data ch%0d k%0d: got %h, expected %h", c, k, obs_wr_data[c][k], model_out(mem[c][k], k, 5)); end
            end
    endtask

    task automatic test_ready_while_busy;
        fill_mem(1'b0);
        do_pass(2'b11, 6'd0, LINES + 6, 100, -1, 1'b0);
        n_vectors++; if (obs_done_q.size() !== 1) begin n_miscompares++; $display("[TB] FAIL busy_ready_count: got %0d, expected 1", obs_done_q.size()); end
        n_vectors++; if ((obs_done_q.size() > 0 ? obs_done_q[0] : -1) !== LINES + 3) begin n_miscompares++; $display("[TB] FAIL busy_ready_cycle: got %0d, expected %0d", (obs_done_q.size() > 0 ? obs_done_q[0] : -1), LINES + 3); end
        n_vectors++; if (obs_busy[LINES + 5] !== 1'b0) begin n_miscompares++; $display("[TB] FAIL busy_ready_restart: got %0b, expected 0", obs_busy[LINES + 5]); end
    endtask

    task automatic test_pure_copy;
        logic [5:0] sbs [2] = '{6'd32, 6'd63};
        for (int p = 0; p < 2; p++) begin
            fill_mem(1'b0);
            do_pass(2'b11, sbs[p], LINES + 6, -1, -1, 1'b0);
            for (int c = 0; c < CH; c++)
                for (int k = 0; k < LINES; k++) begin
                    n_vectors++; if (obs_wr_data[c][k] !== mem[c][k]) begin n_miscompares++; $display("[TB] FAIL copy_sb%0d ch%0d k%0d: got %h, expected %h", sbs[p], c, k, obs_wr_data[c][k], mem[c][k]); end
                end
        end
    endtask

    task automatic test_zero_mask;
        fill_mem(1'b0);
        do_pass(2'b00, 6'd0, LINES + 6, -1, -1, 1'b0);
        n_vectors++; if (obs_we_cnt[0] + obs_we_cnt[1] !== 0) begin n_miscompares++; $display("[TB] FAIL zero_mask_writes: got %0d, expected 0", obs_we_cnt[0] + obs_we_cnt[1]); end
        n_vectors++; if ((obs_done_q.size() > 0 ? obs_done_q[0] : -1) !== LINES + 3) begin n_miscompares++; $display("[TB] FAIL zero_mask_done: got %0d, expected %0d", (obs_done_q.size() > 0 ? obs_done_q[0] : -1), LINES + 3); end
    endtask

    task automatic test_back_to_back;
        fill_mem(1'b0);
        do_pass(2'b11, 6'd0, 2 * LINES + 9, -1, -1, 1'b1);
        n_vectors++; if (obs_done_q.size() !== 2) begin n_miscompares++; $display("[TB] FAIL b2b_count: got %0d, expected 2", obs_done_q.size()); end
        n_vectors++; if ((obs_done_q.size() > 1 ? obs_done_q[1] : -1) !== 2 * LINES + 8) begin n_miscompares++; $display("[TB] FAIL b2b_second_done: got %0d, expected %0d", (obs_done_q.size() > 1 ? obs_done_q[1] : -1), 2 * LINES + 8); end
        n_vectors++; if (obs_busy[LINES + 4] !== 1'b0 || obs_busy[LINES + 5] !== 1'b1) begin n_miscompares++; $display("[TB] FAIL b2b_gap: got %0b%0b, expected 01", obs_busy[LINES + 4], obs_busy[LINES + 5]); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_inversion();
        test_start_sb();
        test_channel_mask();
        test_saturation();
        test_mid_reset();
        test_ready_while_busy();
        test_pure_copy();
        test_zero_mask();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
